// File: rtl/grid_mem_port_a_arbiter_if.sv
// Requester command and read-response bundle for the vga_mem port A arbiter.
// The master side holds both requesters and consumes responses; the slave side is the arbiter.
interface grid_mem_port_a_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 8
);
    logic          req0_valid;
    logic          req0_ready;
    logic          req0_we;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;

    logic          req1_valid;
    logic          req1_ready;
    logic          req1_we;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;

    logic          rsp_valid;
    logic          rsp_id;
    logic [DW-1:0] rsp_data;

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/grid_mem_port_a_arbiter.sv
// Port A owner for vga_mem: round-robin between game logic (0) and line-clear engine (1),
// plus a built-in sweep that fills the whole grid with FILL.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | arbitrating requesters; clear_start launches a sweep
//   ST_CLEAR | writing FILL to addresses 0..DEPTH-1, requesters stalled
module grid_mem_port_a_arbiter #(
    parameter int            AW    = 16,
    parameter int            DW    = 8,
    parameter int            DEPTH = 4096,
    parameter logic [DW-1:0] FILL  = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    grid_mem_port_a_arbiter_if.slave     bus,
    input  logic                         clear_start,
    output logic                         clear_busy,
    output logic                         clear_done,
    output logic [AW-1:0]                mem_addr_a,
    output logic [DW-1:0]                mem_data_a,
    output logic                         mem_we_a,
    input  logic [DW-1:0]                mem_q_a
);
    localparam logic [0:0]    ST_IDLE  = 1'b0;
    localparam logic [0:0]    ST_CLEAR = 1'b1;
    localparam logic [AW-1:0] LAST     = AW'(DEPTH - 1);

    logic [0:0]    state;
    logic [AW-1:0] cnt;
    logic          rr_pri;      // requester favoured on the next tie
    logic          rd_pend;
    logic          rd_id;
    logic          rsp_valid_q;
    logic          rsp_id_q;

    logic          accept_ok;
    logic          gnt0;
    logic          gnt1;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    always_comb begin
        accept_ok = (state == ST_IDLE) && !clear_start;
        gnt0      = accept_ok && bus.req0_valid && (!bus.req1_valid || !rr_pri);
        gnt1      = accept_ok && bus.req1_valid && (!bus.req0_valid ||  rr_pri);
        sel_we    = gnt1 ? bus.req1_we    : bus.req0_we;
        sel_addr  = gnt1 ? bus.req1_addr  : bus.req0_addr;
        sel_wdata = gnt1 ? bus.req1_wdata : bus.req0_wdata;
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_data   = mem_q_a;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            rr_pri      <= 1'b0;
            rd_pend     <= 1'b0;
            rd_id       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            clear_busy  <= 1'b0;
            clear_done  <= 1'b0;
            mem_addr_a  <= '0;
            mem_data_a  <= '0;
            mem_we_a    <= 1'b0;
        end else begin
            clear_done  <= 1'b0;
            rd_pend     <= 1'b0;
            // Read data leaves vga_mem one cycle after the command, so the tag trails by two.
            rsp_valid_q <= rd_pend;
            if (rd_pend) begin
                rsp_id_q <= rd_id;
            end

            if (state == ST_IDLE) begin
                if (clear_start) begin
                    state      <= ST_CLEAR;
                    cnt        <= '0;
                    clear_busy <= 1'b1;
                    mem_we_a   <= 1'b1;
                    mem_addr_a <= '0;
                    mem_data_a <= FILL;
                end else if (gnt0 || gnt1) begin
                    mem_we_a   <= sel_we;
                    mem_addr_a <= sel_addr;
                    mem_data_a <= sel_wdata;
                    rd_pend    <= !sel_we;
                    rd_id      <= gnt1;
                    rr_pri     <= !gnt1;
                end else begin
                    mem_we_a   <= 1'b0;
                end
            end else begin
                // mem_addr_a always equals cnt while sweeping.
                if (cnt == LAST) begin
                    state      <= ST_IDLE;
                    clear_busy <= 1'b0;
                    clear_done <= 1'b1;
                    mem_we_a   <= 1'b0;
                end else begin
                    cnt        <= cnt + AW'(1);
                    mem_addr_a <= cnt + AW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_grid_mem_port_a_arbiter.sv
// Bench for grid_mem_port_a_arbiter: directed scenarios plus random traffic against a
// cycle-level reference of the arbitration, clear sweep and read-response rules.
module tb_grid_mem_port_a_arbiter;
    localparam int            AW    = 16;
    localparam int            DW    = 8;
    localparam int            DEPTH = 16;
    localparam logic [DW-1:0] FILL  = 8'h3C;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    grid_mem_port_a_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    logic          clear_start;
    logic          clear_busy;
    logic          clear_done;
    logic [AW-1:0] mem_addr_a;
    logic [DW-1:0] mem_data_a;
    logic          mem_we_a;
    logic [DW-1:0] mem_q_a;

    grid_mem_port_a_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .FILL(FILL)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .clear_start (clear_start),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done),
        .mem_addr_a  (mem_addr_a),
        .mem_data_a  (mem_data_a),
        .mem_we_a    (mem_we_a),
        .mem_q_a     (mem_q_a)
    );

    // vga_mem port A stand-in: synchronous write, registered read.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_we_a) ram[mem_addr_a] <= mem_data_a;
        mem_q_a <= ram[mem_addr_a];
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    typedef struct {
        int            due;
        bit            id;
        logic [DW-1:0] data;
    } rsp_t;
    rsp_t          exp_q[$];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int            cyc       = 0;
    int            clr_s     = -1000;
    bit            last_win  = 1'b1;
    bit            pend_cmd  = 1'b0;
    bit            pend_we;
    logic [AW-1:0] pend_addr;
    logic [DW-1:0] pend_data;

    always @(negedge clk) begin : monitor
        bit   busy_exp, done_exp, ok, v0, v1, e0, e1;
        int   idx;
        rsp_t r;
        if (rst) begin
            exp_q.delete();
            pend_cmd = 1'b0;
            last_win = 1'b1;
            clr_s    = -1000;
        end else begin
            cyc++;
            busy_exp = (cyc >= clr_s + 1) && (cyc <= clr_s + DEPTH);
            done_exp = (cyc == clr_s + DEPTH + 1);
            idx      = cyc - clr_s - 1;
            // a sweep write becomes visible in memory at the edge after it is presented
            if (busy_exp && idx > 0) ref_mem[idx-1] = FILL;
            if (done_exp) ref_mem[DEPTH-1] = FILL;

            n_checks++;
            if (clear_busy !== busy_exp) begin
                n_fail++;
                $display("FAIL mon_busy cyc %0d: got %b want %b", cyc, clear_busy, busy_exp);
            end
            n_checks++;
            if (clear_done !== done_exp) begin
                n_fail++;
                $display("FAIL mon_done cyc %0d: got %b want %b", cyc, clear_done, done_exp);
            end

            if (busy_exp) begin
                n_checks++;
                if (mem_we_a !== 1'b1 || mem_addr_a !== AW'(idx) || mem_data_a !== FILL) begin
                    n_fail++;
                    $display("FAIL mon_clear_wr cyc %0d: got we=%b a=%0d d=%h want we=1 a=%0d d=%h",
                             cyc, mem_we_a, mem_addr_a, mem_data_a, idx, FILL);
                end
            end else if (pend_cmd) begin
                n_checks++;
                if (mem_we_a !== pend_we || mem_addr_a !== pend_addr ||
                    (pend_we && mem_data_a !== pend_data)) begin
                    n_fail++;
                    $display("FAIL mon_cmd cyc %0d: got we=%b a=%0d d=%h want we=%b a=%0d d=%h",
                             cyc, mem_we_a, mem_addr_a, mem_data_a, pend_we, pend_addr, pend_data);
                end
            end else begin
                n_checks++;
                if (mem_we_a !== 1'b0) begin
                    n_fail++;
                    $display("FAIL mon_idle_we cyc %0d: got %b want 0", cyc, mem_we_a);
                end
            end

            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                r = exp_q.pop_front();
                n_checks++;
                if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== r.id || bus.rsp_data !== r.data) begin
                    n_fail++;
                    $display("FAIL mon_rsp cyc %0d: got v=%b id=%b d=%h want v=1 id=%b d=%h",
                             cyc, bus.rsp_valid, bus.rsp_id, bus.rsp_data, r.id, r.data);
                end
            end else begin
                n_checks++;
                if (bus.rsp_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL mon_rsp_idle cyc %0d: got %b want 0", cyc, bus.rsp_valid);
                end
            end

            v0 = (bus.req0_valid === 1'b1);
            v1 = (bus.req1_valid === 1'b1);
            ok = !busy_exp && (clear_start !== 1'b1);
            e0 = ok && v0 && (!v1 || last_win);
            e1 = ok && v1 && (!v0 || !last_win);
            n_checks++;
            if (bus.req0_ready !== e0 || bus.req1_ready !== e1) begin
                n_fail++;
                $display("FAIL mon_ready cyc %0d: got r0=%b r1=%b want r0=%b r1=%b",
                         cyc, bus.req0_ready, bus.req1_ready, e0, e1);
            end

            pend_cmd = 1'b0;
            if (e0 || e1) begin
                pend_cmd  = 1'b1;
                pend_we   = e1 ? bus.req1_we    : bus.req0_we;
                pend_addr = e1 ? bus.req1_addr  : bus.req0_addr;
                pend_data = e1 ? bus.req1_wdata : bus.req0_wdata;
                last_win  = e1;
                if (pend_we) begin
                    ref_mem[pend_addr] = pend_data;
                end else begin
                    r.due  = cyc + 2;
                    r.id   = e1;
                    r.data = ref_mem[pend_addr];
                    exp_q.push_back(r);
                end
            end
            if (ok && !v0 && !v1 && clear_start === 1'b1) clr_s = cyc;
            else if (!busy_exp && clear_start === 1'b1) clr_s = cyc;
        end
    end

    task automatic drive_idle();
        bus.req0_valid = 1'b0; bus.req0_we = 1'b0; bus.req0_addr = '0; bus.req0_wdata = '0;
        bus.req1_valid = 1'b0; bus.req1_we = 1'b0; bus.req1_addr = '0; bus.req1_wdata = '0;
        clear_start    = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #22;
        n_checks++;
        if ({mem_we_a, mem_addr_a, mem_data_a} !== '0) begin
            n_fail++;
            $display("FAIL reset_mem: got we=%b a=%h d=%h want all 0", mem_we_a, mem_addr_a, mem_data_a);
        end
        n_checks++;
        if ({bus.rsp_valid, bus.rsp_id, clear_busy, clear_done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got rv=%b rid=%b busy=%b done=%b want 0",
                     bus.rsp_valid, bus.rsp_id, clear_busy, clear_done);
        end
        @(posedge clk); #1 rst = 1'b0;
        idle_cycles(2);
    endtask

    task automatic test_fairness();
        bit exp1;
        bus.req0_valid = 1'b1; bus.req0_we = 1'b0; bus.req0_addr = 16'd10;
        bus.req1_valid = 1'b1; bus.req1_we = 1'b0; bus.req1_addr = 16'd20;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i < 6) begin
                exp1 = (i % 2 == 1);
                n_checks++;
                if (bus.req0_ready !== !exp1 || bus.req1_ready !== exp1) begin
                    n_fail++;
                    $display("FAIL fair_grant %0d: got r0=%b r1=%b want r0=%b r1=%b",
                             i, bus.req0_ready, bus.req1_ready, !exp1, exp1);
                end
            end
            if (i >= 2) begin
                exp1 = ((i - 2) % 2 == 1);
                n_checks++;
                if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== exp1) begin
                    n_fail++;
                    $display("FAIL fair_rsp %0d: got v=%b id=%b want v=1 id=%b",
                             i, bus.rsp_valid, bus.rsp_id, exp1);
                end
            end
            @(posedge clk); #1;
            if (i == 5) drive_idle();
        end
        idle_cycles(2);
    endtask

    task automatic test_write_read();
        bus.req0_valid = 1'b1; bus.req0_we = 1'b1; bus.req0_addr = 16'd5; bus.req0_wdata = 8'hA5;
        @(negedge clk);
        n_checks++;
        if (bus.req0_ready !== 1'b1) begin
            n_fail++; $display("FAIL wr_accept: got %b want 1", bus.req0_ready);
        end
        @(posedge clk); #1 bus.req0_we = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.req0_ready !== 1'b1) begin
            n_fail++; $display("FAIL rd_accept: got %b want 1", bus.req0_ready);
        end
        @(posedge clk); #1 drive_idle();
        @(negedge clk);
        n_checks++;
        if (bus.rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL rd_early: got rsp_valid %b want 0", bus.rsp_valid);
        end
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 || bus.rsp_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL rd_rsp: got v=%b id=%b d=%h want v=1 id=0 d=a5",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_data);
        end
        idle_cycles(2);
    endtask

    task automatic test_clear();
        int busy_cnt = 0, done_cnt = 0, nxt = 0;
        clear_start = 1'b1;
        @(negedge clk);
        n_checks++;
        if (clear_busy !== 1'b0) begin
            n_fail++; $display("FAIL clr_start_busy: got %b want 0", clear_busy);
        end
        @(posedge clk); #1 clear_start = 1'b0;
        for (int i = 0; i < DEPTH + 4; i++) begin
            @(negedge clk);
            if (clear_busy === 1'b1) busy_cnt++;
            if (clear_done === 1'b1) done_cnt++;
            if (mem_we_a === 1'b1) begin
                n_checks++;
                if (mem_addr_a !== AW'(nxt) || mem_data_a !== FILL) begin
                    n_fail++;
                    $display("FAIL clr_write %0d: got a=%0d d=%h want a=%0d d=%h",
                             nxt, mem_addr_a, mem_data_a, nxt, FILL);
                end
                nxt++;
            end
        end
        n_checks++;
        if (busy_cnt != DEPTH || nxt != DEPTH || done_cnt != 1) begin
            n_fail++;
            $display("FAIL clr_counts: got busy=%0d writes=%0d done=%0d want %0d %0d 1",
                     busy_cnt, nxt, done_cnt, DEPTH, DEPTH);
        end
        @(posedge clk); #1;
        bus.req0_valid = 1'b1; bus.req0_we = 1'b0; bus.req0_addr = 16'd0;
        @(negedge clk);
        @(posedge clk); #1 bus.req0_addr = AW'(DEPTH - 1);
        @(negedge clk);
        @(posedge clk); #1 drive_idle();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== FILL) begin
                n_fail++;
                $display("FAIL clr_readback %0d: got v=%b d=%h want v=1 d=%h",
                         i, bus.rsp_valid, bus.rsp_data, FILL);
            end
            @(posedge clk);
        end
        idle_cycles(2);
    endtask

    task automatic test_contention();
        clear_start    = 1'b1;
        bus.req1_valid = 1'b1; bus.req1_we = 1'b0; bus.req1_addr = 16'd3;
        @(negedge clk);
        n_checks++;
        if (bus.req1_ready !== 1'b0) begin
            n_fail++; $display("FAIL cont_start: got req1_ready %b want 0", bus.req1_ready);
        end
        @(posedge clk); #1 clear_start = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clk);
            n_checks++;
            if (clear_busy !== 1'b1 || bus.req1_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL cont_hold %0d: got busy=%b r1=%b want busy=1 r1=0",
                         k, clear_busy, bus.req1_ready);
            end
        end
        @(negedge clk);
        n_checks++;
        if (clear_busy !== 1'b0 || bus.req1_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL cont_release: got busy=%b r1=%b want busy=0 r1=1", clear_busy, bus.req1_ready);
        end
        @(posedge clk); #1 drive_idle();
        idle_cycles(3);
    endtask

    task automatic test_reset_mid_clear();
        bit found = 1'b0;
        int done_cnt = 0, busy_cnt = 0;
        clear_start = 1'b1;
        @(posedge clk); #1 clear_start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (mem_we_a === 1'b1 && mem_addr_a === 16'd7) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!found) begin
            n_fail++; $display("FAIL rst_find_addr7: got no write to 7 want one");
        end
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({mem_we_a, mem_addr_a, mem_data_a, bus.rsp_valid, bus.rsp_id, clear_busy, clear_done} !== '0) begin
            n_fail++;
            $display("FAIL rst_outputs: got we=%b a=%h d=%h rv=%b rid=%b busy=%b done=%b want all 0",
                     mem_we_a, mem_addr_a, mem_data_a, bus.rsp_valid, bus.rsp_id, clear_busy, clear_done);
        end
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        for (int k = 0; k < DEPTH + 8; k++) begin
            @(negedge clk);
            if (clear_done === 1'b1) done_cnt++;
            if (clear_busy === 1'b1) busy_cnt++;
        end
        n_checks++;
        if (done_cnt != 0 || busy_cnt != 0) begin
            n_fail++;
            $display("FAIL rst_aborted: got done=%0d busy=%0d want 0 0", done_cnt, busy_cnt);
        end
        @(posedge clk); #1;
        bus.req0_valid = 1'b1; bus.req0_we = 1'b0; bus.req0_addr = 16'd8;
        @(negedge clk);
        n_checks++;
        if (bus.req0_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_after_accept: got %b want 1", bus.req0_ready);
        end
        @(posedge clk); #1 drive_idle();
        idle_cycles(3);
    endtask

    task automatic test_hazard();
        bus.req1_valid = 1'b1; bus.req1_we = 1'b1; bus.req1_addr = 16'd300; bus.req1_wdata = 8'h55;
        @(negedge clk);
        n_checks++;
        if (bus.req1_ready !== 1'b1) begin
            n_fail++; $display("FAIL haz_wr_accept: got %b want 1", bus.req1_ready);
        end
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_we = 1'b0; bus.req0_addr = 16'd300;
        @(negedge clk);
        n_checks++;
        if (bus.req0_ready !== 1'b1) begin
            n_fail++; $display("FAIL haz_rd_accept: got %b want 1", bus.req0_ready);
        end
        @(posedge clk); #1 drive_idle();
        @(negedge clk);
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 || bus.rsp_data !== 8'h55) begin
            n_fail++;
            $display("FAIL haz_rsp: got v=%b id=%b d=%h want v=1 id=0 d=55",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_data);
        end
        idle_cycles(2);
    endtask

    task automatic test_random();
        bit a0 = 1'b1, a1 = 1'b1;
        for (int i = 0; i < 500; i++) begin
            if (!bus.req0_valid || a0) begin
                bus.req0_valid = ($urandom_range(0, 1) == 1);
                bus.req0_we    = ($urandom_range(0, 2) == 0);
                bus.req0_addr  = AW'($urandom_range(0, 31));
                bus.req0_wdata = DW'($urandom);
            end
            if (!bus.req1_valid || a1) begin
                bus.req1_valid = ($urandom_range(0, 1) == 1);
                bus.req1_we    = ($urandom_range(0, 2) == 0);
                bus.req1_addr  = AW'($urandom_range(0, 31));
                bus.req1_wdata = DW'($urandom);
            end
            clear_start = ($urandom_range(0, 79) == 0);
            @(negedge clk);
            a0 = (bus.req0_valid === 1'b1) && (bus.req0_ready === 1'b1);
            a1 = (bus.req1_valid === 1'b1) && (bus.req1_ready === 1'b1);
            @(posedge clk); #1;
        end
        drive_idle();
        idle_cycles(DEPTH + 4);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL rand_drain: got %0d outstanding responses want 0", exp_q.size());
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i]     = '0;
            ref_mem[i] = '0;
        end
        drive_idle();
        test_reset();
        test_fairness();
        test_write_read();
        test_clear();
        test_contention();
        test_reset_mid_clear();
        test_hazard();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
